// File: rtl/noc_if.sv
// noc_if: credit-based flit link between a transmitter and a receiver.
//   valid  [VC_W]  one bit per virtual channel, flit present this cycle
//   data   [F_W]   flit shared by all VCs
//   credit [VC_W]  one-cycle credit return pulses, receiver -> transmitter
// Modports: transmitter/receiver, with master/slave as aliases.
interface noc_if #(
  parameter int unsigned VC_W = 2,
  parameter int unsigned F_W  = 11
);
  logic [VC_W-1:0] valid;
  logic [F_W-1:0]  data;
  logic [VC_W-1:0] credit;

  modport transmitter (output valid, output data, input  credit);
  modport receiver    (input  valid, input  data, output credit);
  modport master      (output valid, output data, input  credit);
  modport slave       (input  valid, input  data, output credit);
endinterface

// File: rtl/pi_client_endpoint.sv
// pi_client_endpoint: attaches one client to a pi_switch tree port.
//   clk, rst_n          clock, asynchronous active-low reset
//   to_rx   (tx side)   flits toward the switch, one credit counter per VC
//   from_tx (rx side)   flits from the switch into per-VC FIFOs, credits returned
//   inj_v/inj_d/inj_vc/inj_rdy   client injection stream
//   ej_v/ej_d/ej_vc/ej_rdy       client ejection stream (registered outputs)
//   err                 sticky: credit overflow, FIFO overflow, wrong destination
// Flit layout: {addr[A_W-1:0], payload[D_W-1:0], flag}.
// Optional macro PI_CLIENT_ENDPOINT_STATS_EN adds inj_cnt/ej_cnt/stall_cnt.
module pi_client_endpoint #(
  parameter int unsigned N             = 4,
  parameter int unsigned A_W           = 2,
  parameter int unsigned D_W           = 8,
  parameter int unsigned VC_W          = 2,
  parameter int unsigned VC_FIFO_DEPTH = 4,
  parameter int unsigned CLIENT_ID     = 0,
  localparam int unsigned F_W   = A_W + D_W + 1,
  localparam int unsigned VCI_W = (VC_W > 1) ? $clog2(VC_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_if.transmitter       to_rx,
  noc_if.receiver          from_tx,
  input  logic             inj_v,
  input  logic [F_W-1:0]   inj_d,
  input  logic [VCI_W-1:0] inj_vc,
  output logic             inj_rdy,
  output logic             ej_v,
  output logic [F_W-1:0]   ej_d,
  output logic [VCI_W-1:0] ej_vc,
  input  logic             ej_rdy,
  output logic             err
`ifdef PI_CLIENT_ENDPOINT_STATS_EN
  ,
  output logic [31:0]      inj_cnt,
  output logic [31:0]      ej_cnt,
  output logic [31:0]      stall_cnt
`endif
);
  localparam int unsigned USE  = VC_FIFO_DEPTH - 1;
  localparam int unsigned CW   = (VC_FIFO_DEPTH > 2) ? $clog2(VC_FIFO_DEPTH) : 1;
  localparam int unsigned PW   = (USE > 1) ? $clog2(USE) : 1;
  localparam int unsigned CNTW = $clog2(USE + 1);
  localparam logic [CW-1:0]   CR_MAX  = CW'(USE);
  // Ids outside 0..N-1 fold into the address range.
  localparam logic [A_W-1:0]  MY_ADDR = A_W'(CLIENT_ID % N);

  function automatic logic [VCI_W-1:0] nxt_vc(input logic [VCI_W-1:0] v);
    return VCI_W'((32'(v) + 1) % VC_W);
  endfunction

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (32'(p) == USE - 1) ? '0 : p + 1'b1;
  endfunction

  // ---------------- injection ----------------
  logic            live;
  logic [CW-1:0]   credits [VC_W];
  logic [VC_W-1:0] send;
  logic            cr_ovf;

  always_comb begin
    inj_rdy = live && (credits[inj_vc] != '0);
    send    = '0;
    if (inj_v && inj_rdy) send[inj_vc] = 1'b1;
    cr_ovf = 1'b0;
    for (int unsigned v = 0; v < VC_W; v++)
      if (to_rx.credit[v] && !send[v] && credits[v] == CR_MAX) cr_ovf = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live        <= 1'b0;
      to_rx.valid <= '0;
      to_rx.data  <= '0;
      for (int unsigned v = 0; v < VC_W; v++) credits[v] <= CR_MAX;
    end else begin
      live        <= 1'b1;
      to_rx.valid <= send;
      if (|send) to_rx.data <= inj_d;
      for (int unsigned v = 0; v < VC_W; v++) begin
        if (send[v] && !to_rx.credit[v])
          credits[v] <= credits[v] - 1'b1;
        else if (!send[v] && to_rx.credit[v] && credits[v] != CR_MAX)
          credits[v] <= credits[v] + 1'b1;
      end
    end
  end

  // ---------------- ejection ----------------
  logic [F_W-1:0]   mem    [VC_W][USE];
  logic [PW-1:0]    rd_ptr [VC_W];
  logic [PW-1:0]    wr_ptr [VC_W];
  logic [CNTW-1:0]  cnt    [VC_W];
  logic [F_W-1:0]   cand_d [VC_W];
  logic [VC_W-1:0]  pop, wr_en, cand;
  logic [VCI_W-1:0] rr, start, win, idx;
  logic [CNTW-1:0]  eff;
  logic [PW-1:0]    head;
  logic             found, load, drop, dest_err;

  // The output register always holds a copy of the head of FIFO ej_vc; the
  // entry is popped only when the client takes it. On that pop the register
  // is refilled from the post-pop view, where an arriving flit into an empty
  // FIFO is visible in the same cycle it is written.
  always_comb begin
    pop = '0;
    if (ej_v && ej_rdy) pop[ej_vc] = 1'b1;
    load  = !ej_v || ej_rdy;
    start = (|pop) ? nxt_vc(ej_vc) : rr;
    wr_en = '0;
    cand  = '0;
    eff   = '0;
    head  = '0;
    for (int unsigned v = 0; v < VC_W; v++) begin
      wr_en[v]  = from_tx.valid[v] && (cnt[v] != CNTW'(USE) || pop[v]);
      eff       = cnt[v] - CNTW'(pop[v]);
      head      = pop[v] ? nxt_ptr(rd_ptr[v]) : rd_ptr[v];
      cand[v]   = (eff != '0) || wr_en[v];
      cand_d[v] = (eff != '0) ? mem[v][head] : from_tx.data;
    end
    drop     = |(from_tx.valid & ~wr_en);
    dest_err = (|from_tx.valid) && (from_tx.data[F_W-1 -: A_W] != MY_ADDR);
    found = 1'b0;
    win   = start;
    idx   = '0;
    for (int unsigned i = 0; i < VC_W; i++) begin
      idx = VCI_W'((32'(start) + i) % VC_W);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < VC_W; v++)
      if (wr_en[v]) mem[v][wr_ptr[v]] <= from_tx.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < VC_W; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      from_tx.credit <= '0;
      rr    <= '0;
      ej_v  <= 1'b0;
      ej_d  <= '0;
      ej_vc <= '0;
      err   <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VC_W; v++) begin
        if (wr_en[v]) wr_ptr[v] <= nxt_ptr(wr_ptr[v]);
        if (pop[v])   rd_ptr[v] <= nxt_ptr(rd_ptr[v]);
        cnt[v] <= cnt[v] + CNTW'(wr_en[v]) - CNTW'(pop[v]);
      end
      from_tx.credit <= pop;
      if (|pop) rr <= nxt_vc(ej_vc);
      if (load) begin
        ej_v <= found;
        if (found) begin
          ej_d  <= cand_d[win];
          ej_vc <= win;
        end
      end
      err <= err | cr_ovf | drop | dest_err;
    end
  end

`ifdef PI_CLIENT_ENDPOINT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_cnt   <= '0;
      ej_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (inj_v && inj_rdy)  inj_cnt   <= inj_cnt + 1'b1;
      if (ej_v && ej_rdy)    ej_cnt    <= ej_cnt + 1'b1;
      if (inj_v && !inj_rdy) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pi_client_endpoint.sv
module tb_pi_client_endpoint;
  localparam int VC  = 2;
  localparam int DEP = 4;
  localparam int USE = DEP - 1;
  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int FW  = AW + DW + 1;
  localparam logic [AW-1:0] ID = 2'd1;

  logic          clk;
  logic          rst_n;
  logic          inj_v;
  logic [FW-1:0] inj_d;
  logic [0:0]    inj_vc;
  logic          inj_rdy;
  logic          ej_v;
  logic [FW-1:0] ej_d;
  logic [0:0]    ej_vc;
  logic          ej_rdy;
  logic          err;
`ifdef PI_CLIENT_ENDPOINT_STATS_EN
  logic [31:0]   inj_cnt, ej_cnt, stall_cnt;
`endif

  noc_if #(.VC_W(VC), .F_W(FW)) to_rx_bus ();
  noc_if #(.VC_W(VC), .F_W(FW)) from_tx_bus ();

  pi_client_endpoint #(
    .N(4), .A_W(AW), .D_W(DW), .VC_W(VC), .VC_FIFO_DEPTH(DEP), .CLIENT_ID(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .to_rx(to_rx_bus), .from_tx(from_tx_bus),
    .inj_v(inj_v), .inj_d(inj_d), .inj_vc(inj_vc), .inj_rdy(inj_rdy),
    .ej_v(ej_v), .ej_d(ej_d), .ej_vc(ej_vc), .ej_rdy(ej_rdy), .err(err)
`ifdef PI_CLIENT_ENDPOINT_STATS_EN
    , .inj_cnt(inj_cnt), .ej_cnt(ej_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {a, d, 1'b1};
  endfunction

  // ---------------- behavioural model ----------------
  // Credits as integers, ejection FIFOs as ordered lists, output register as
  // the list head chosen by round-robin whenever the client slot is free.
  int            m_cred [VC] = '{USE, USE};
  bit            m_live = 0;
  logic [VC-1:0] m_txv = '0;
  logic [FW-1:0] m_txd = '0;
  logic [FW-1:0] m_fifo [VC][USE];
  int            m_n [VC] = '{0, 0};
  bit            m_ejv = 0;
  logic [FW-1:0] m_ejd = '0;
  int            m_ejvc = 0;
  int            m_ptr = 0;
  logic [VC-1:0] m_cr = '0;
  bit            m_err = 0;
  int            m_inj = 0, m_ej = 0, m_stall = 0;
  bit            m_rdy, m_acc, m_load;
  int            c, w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VC; v++) begin m_cred[v] = USE; m_n[v] = 0; end
      m_live = 0; m_txv = '0; m_txd = '0; m_ejv = 0; m_ejd = '0; m_ejvc = 0;
      m_ptr = 0; m_cr = '0; m_err = 0; m_inj = 0; m_ej = 0; m_stall = 0;
    end else begin
      m_rdy  = m_live && m_cred[inj_vc] != 0;
      m_acc  = inj_v && m_rdy;
      m_load = !m_ejv || ej_rdy;
      if (m_acc) m_inj++;
      if (inj_v && !m_rdy) m_stall++;
      for (int v = 0; v < VC; v++) begin
        c = m_cred[v] - ((m_acc && inj_vc == 1'(v)) ? 1 : 0) + (to_rx_bus.credit[v] ? 1 : 0);
        if (c > USE) begin c = USE; m_err = 1; end
        m_cred[v] = c;
      end
      m_txv = '0;
      if (m_acc) begin m_txv[inj_vc] = 1'b1; m_txd = inj_d; end
      m_cr = '0;
      if (m_ejv && ej_rdy) begin
        for (int k = 0; k < USE - 1; k++) m_fifo[m_ejvc][k] = m_fifo[m_ejvc][k+1];
        m_n[m_ejvc]--;
        m_cr[m_ejvc] = 1'b1;
        m_ptr = (m_ejvc + 1) % VC;
        m_ej++;
      end
      for (int v = 0; v < VC; v++) begin
        if (from_tx_bus.valid[v]) begin
          if (from_tx_bus.data[FW-1 -: AW] != ID) m_err = 1;
          if (m_n[v] < USE) begin m_fifo[v][m_n[v]] = from_tx_bus.data; m_n[v]++; end
          else m_err = 1;
        end
      end
      if (m_load) begin
        m_ejv = 0;
        for (int i = 0; i < VC; i++) begin
          w = (m_ptr + i) % VC;
          if (!m_ejv && m_n[w] > 0) begin m_ejv = 1; m_ejd = m_fifo[w][0]; m_ejvc = w; end
        end
      end
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    chk("inj_rdy", inj_rdy, m_live && m_cred[inj_vc] != 0);
    chk("tx_valid", to_rx_bus.valid, m_txv);
    if (m_txv != '0) chk("tx_data", to_rx_bus.data, m_txd);
    chk("credit_out", from_tx_bus.credit, m_cr);
    chk("ej_v", ej_v, m_ejv);
    if (m_ejv) begin
      chk("ej_d", ej_d, m_ejd);
      chk("ej_vc", ej_vc, m_ejvc);
    end
    chk("err", err, m_err);
`ifdef PI_CLIENT_ENDPOINT_STATS_EN
    chk("inj_cnt", inj_cnt, m_inj);
    chk("ej_cnt", ej_cnt, m_ej);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  end

  // ---------------- watcher for literal sequence checks ----------------
  bit watch = 0;
  int seq[$];
  int cr_pulses = 0;
  always @(negedge clk) begin
    if (watch) begin
      if (ej_v && ej_rdy) seq.push_back(int'(ej_vc));
      cr_pulses += $countones(from_tx_bus.credit);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    inj_v = 1'b0; inj_d = '0; inj_vc = '0; ej_rdy = 1'b0;
    to_rx_bus.credit = '0; from_tx_bus.valid = '0; from_tx_bus.data = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk("rst_inj_rdy", inj_rdy, 0);
    chk("rst_ej_v", ej_v, 0);
    chk("rst_err", err, 0);
    chk("rst_tx_valid", to_rx_bus.valid, 0);
    chk("rst_tx_data", to_rx_bus.data, 0);
    chk("rst_credit_out", from_tx_bus.credit, 0);
    do_reset();

    // credit exhaustion on VC0
    inj_vc = 1'b0; inj_v = 1'b1;
    for (int i = 0; i < 3; i++) begin inj_d = mk(ID, 8'(8'h10 + i)); tick(); end
    inj_v = 1'b0;
    #2 chk("p1_rdy_vc0_empty", inj_rdy, 0);
    inj_vc = 1'b1;
    #1 chk("p1_rdy_vc1", inj_rdy, 1);
    to_rx_bus.credit = 2'b01;
    tick();
    to_rx_bus.credit = 2'b00; inj_vc = 1'b0;
    #2 chk("p1_rdy_vc0_back", inj_rdy, 1);
    tick();

    // simultaneous send and credit return on VC1 at credits=1
    inj_vc = 1'b1; inj_v = 1'b1;
    for (int i = 0; i < 2; i++) begin inj_d = mk(ID, 8'(8'h30 + i)); tick(); end
    to_rx_bus.credit = 2'b10;
    for (int i = 0; i < 10; i++) begin
      inj_d = mk(ID, 8'(8'h40 + i));
      #2 chk("p2_rdy_held", inj_rdy, 1);
      tick();
    end
    inj_v = 1'b0; to_rx_bus.credit = 2'b00;
    #2 chk("p2_last_tx", to_rx_bus.data, mk(ID, 8'h49));
    tick();

    // ejection fairness
    seq.delete(); cr_pulses = 0; watch = 1;
    from_tx_bus.valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      from_tx_bus.data = mk(ID, 8'(8'h50 + i));
      tick();
      if (i == 0) #2 chk("p3_ej_latency", ej_v, 1);
    end
    from_tx_bus.valid = 2'b00;
    ej_rdy = 1'b1;
    repeat (8) tick();
    ej_rdy = 1'b0;
    tick();
    watch = 0;
    chk("p3_npops", seq.size(), 6);
    for (int i = 0; i < seq.size() && i < 6; i++) chk("p3_vc_order", seq[i], i % 2);
    chk("p3_credit_pulses", cr_pulses, 6);

    // backpressure and FIFO overflow on VC0
    cr_pulses = 0; watch = 1;
    from_tx_bus.valid = 2'b01;
    for (int i = 0; i < 3; i++) begin from_tx_bus.data = mk(ID, 8'(8'h60 + i)); tick(); end
    from_tx_bus.valid = 2'b00;
    #2 chk("p4_ej_d_hold", ej_d, mk(ID, 8'h60));
    chk("p4_err_clear", err, 0);
    tick();
    from_tx_bus.valid = 2'b01; from_tx_bus.data = mk(ID, 8'h63);
    tick();
    from_tx_bus.valid = 2'b00;
    #2 chk("p4_err_set", err, 1);
    repeat (3) tick();
    chk("p4_err_sticky", err, 1);
    chk("p4_ej_d_hold2", ej_d, mk(ID, 8'h60));
    chk("p4_no_credit", cr_pulses, 0);
    watch = 0;

    // asynchronous reset mid-traffic
    inj_vc = 1'b0; inj_v = 1'b1; inj_d = mk(ID, 8'h70);
    tick();
    inj_v = 1'b0;
    chk("p5_tx_before", to_rx_bus.valid, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    chk("p5_tx_valid", to_rx_bus.valid, 0);
    chk("p5_tx_data", to_rx_bus.data, 0);
    chk("p5_ej_v", ej_v, 0);
    chk("p5_ej_d", ej_d, 0);
    chk("p5_credit_out", from_tx_bus.credit, 0);
    chk("p5_err", err, 0);
    chk("p5_inj_rdy", inj_rdy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("p5_ej_v_after", ej_v, 0);
    inj_v = 1'b1;
    for (int i = 0; i < 3; i++) begin inj_d = mk(ID, 8'(8'h78 + i)); tick(); end
    inj_v = 1'b0;
    #2 chk("p5_three_credits", inj_rdy, 0);
    tick();

    // destination check: delivered, but flagged
    ej_rdy = 1'b1;
    from_tx_bus.valid = 2'b01; from_tx_bus.data = mk(2'd2, 8'h80);
    tick();
    from_tx_bus.valid = 2'b00;
    #2 chk("p6_dest_err", err, 1);
    chk("p6_dest_delivered", ej_d, mk(2'd2, 8'h80));
    tick();

    // credit return above the reset value saturates and flags
    do_reset();
    to_rx_bus.credit = 2'b10;
    tick();
    to_rx_bus.credit = 2'b00;
    inj_vc = 1'b1;
    #2 chk("p6_cred_ovf_err", err, 1);
    chk("p6_cred_ovf_rdy", inj_rdy, 1);
    tick();

`ifdef PI_CLIENT_ENDPOINT_STATS_EN
    do_reset();
    inj_vc = 1'b0; inj_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) inj_vc = 1'b0;
      inj_d = mk(ID, 8'(8'h90 + i));
      tick();
    end
    inj_vc = 1'b1;
    for (int i = 0; i < 2; i++) begin inj_d = mk(ID, 8'(8'hA0 + i)); tick(); end
    inj_v = 1'b0;
    ej_rdy = 1'b1;
    from_tx_bus.valid = 2'b10;
    for (int i = 0; i < 4; i++) begin from_tx_bus.data = mk(ID, 8'(8'hB0 + i)); tick(); end
    from_tx_bus.valid = 2'b00;
    repeat (3) tick();
    chk("stats_inj", inj_cnt, 5);
    chk("stats_stall", stall_cnt, 2);
    chk("stats_ej", ej_cnt, 4);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
